trace_pkt_serializer: RTL and testbench
=======================================

TRACE_PKT_SERIALIZER -- requirements
Module: trace_pkt_serializer

Interface
REQ-001 SHALL have parameter IN_WIDTH, default AXI_DATA_WIDTH, width of the wide trace packet from the monitoring system.
REQ-002 SHALL have parameter OUT_WIDTH, default 64, width of the narrow DMA-side beat.
REQ-003 SHALL have port clk  input  1  clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port S_AXIS_tvalid  input  1  wide packet valid.
REQ-006 SHALL have port S_AXIS_tready  output  1  wide packet accepted.
REQ-007 SHALL have port S_AXIS_tdata  input  IN_WIDTH  wide packet payload.
REQ-008 SHALL have port S_AXIS_tlast  input  1  end-of-transfer marker of wide packet.
REQ-009 SHALL have port M_AXIS_tvalid  output  1  narrow beat valid.
REQ-010 SHALL have port M_AXIS_tready  input  1  downstream ready.
REQ-011 SHALL have port M_AXIS_tdata  output  OUT_WIDTH  narrow beat payload.
REQ-012 SHALL have port M_AXIS_tlast  output  1  end-of-transfer marker of narrow stream.
REQ-013 SHALL have port pkt_count  output  32  number of wide packets accepted since reset.
REQ-014 SHALL have port busy  output  1  high while a packet is held.

Function
REQ-015 SHALL define NUM_BEATS = IN_WIDTH / OUT_WIDTH; elaboration SHALL fail if IN_WIDTH is not an integer multiple of OUT_WIDTH or NUM_BEATS < 2.
REQ-016 SHALL implement FSM states IDLE and SEND (plus HEADER, see REQ-029); IDLE -> SEND on input handshake; SEND -> IDLE on last-beat handshake with no new input accepted that cycle.
REQ-017 SHALL capture S_AXIS_tdata and S_AXIS_tlast into a holding register on handshake (tvalid & tready).
REQ-018 SHALL drive S_AXIS_tready = 1 in IDLE, and in SEND only when on the last beat and M_AXIS_tready = 1 (back-to-back packets, no bubble).
REQ-019 SHALL emit beats least-significant slice first: beat k = holding[k*OUT_WIDTH +: OUT_WIDTH], k = 0..NUM_BEATS-1.
REQ-020 SHALL advance the beat index only on output handshake; M_AXIS_tdata and M_AXIS_tvalid SHALL stay stable while tvalid & ~tready.
REQ-021 SHALL assert M_AXIS_tlast only on beat NUM_BEATS-1 of a packet whose captured tlast was 1.
REQ-022 SHALL assert M_AXIS_tvalid from the cycle after input handshake (latency 1) while in SEND/HEADER.
REQ-023 SHALL increment pkt_count by 1 per input handshake, wrapping 0xFFFFFFFF -> 0.
REQ-024 SHALL drive busy = 1 whenever state != IDLE.
REQ-025 Simultaneous last-beat output handshake and input handshake SHALL load the new packet, reset beat index to 0, and remain in SEND (or HEADER).

Reset
REQ-026 On rst_n low SHALL force state IDLE, beat index 0, holding register 0, pkt_count 0, M_AXIS_tvalid 0, M_AXIS_tlast 0, M_AXIS_tdata 0.
REQ-027 Reset mid-packet SHALL discard remaining beats; no partial packet SHALL be emitted after rst_n deasserts.
REQ-028 S_AXIS_tready SHALL be 0 while rst_n is low and 1 in the first cycle after deassertion.

Configuration
REQ-029 Macro TRACE_PKT_SERIALIZER_SEQ_HEADER_EN defined: each packet SHALL be preceded by one HEADER beat {seq[31:0], NUM_BEATS[15:0], 16'hC5A1} (MSB to LSB, zero-extended to OUT_WIDTH), where seq = pkt_count value before the increment; HEADER -> SEND on header handshake; the header beat SHALL never carry tlast.
REQ-030 Macro undefined: no HEADER state, no header beat; packets are exactly NUM_BEATS beats.

Structure
REQ-031 The HEADER magic constant 16'hC5A1 and the FSM state enum type SHALL reside in continuous_monitoring_system_pkg alongside AXI_DATA_WIDTH.
REQ-032 SHALL be a single module with no sub-modules.

Verification (IN_WIDTH=256, OUT_WIDTH=64, NUM_BEATS=4)
REQ-033 Single packet 0x0004_..._0003_..._0002_..._0001 (slices 1..4), tlast=1, M_AXIS_tready=1 -> beats 1,2,3,4 on cycles 1..4 after handshake, tlast on beat 4 only, pkt_count=1.
REQ-034 Two packets back-to-back, tready=1 -> 8 consecutive valid beats with no gap, S_AXIS_tready high exactly on the handshake cycles.
REQ-035 M_AXIS_tready toggled 1,0,0,1 pattern -> beat data held stable during stalls, 4 beats total, no duplicated or skipped slice.
REQ-036 rst_n pulsed low after beat 2 -> M_AXIS_tvalid=0 immediately, pkt_count=0, next packet starts at slice 0.
REQ-037 With TRACE_PKT_SERIALIZER_SEQ_HEADER_EN, three packets -> 15 beats; header seq fields 0, 1, 2; header low 32 bits 0x0004_C5A1.

Source files
------------

// File: rtl/continuous_monitoring_system_pkg.sv
// Shared definitions for the continuous monitoring trace path.
// TRACE_PKT_SERIALIZER_SEQ_HEADER_EN adds the HEADER state to the serializer FSM.
package continuous_monitoring_system_pkg;

    localparam int unsigned AXI_DATA_WIDTH = 256;
    localparam logic [15:0] HDR_MAGIC      = 16'hC5A1;

`ifdef TRACE_PKT_SERIALIZER_SEQ_HEADER_EN
    typedef enum logic [1:0] {
        IDLE,
        SEND,
        HEADER
    } ser_state_t;
`else
    typedef enum logic [0:0] {
        IDLE,
        SEND
    } ser_state_t;
`endif

endpackage

// File: rtl/trace_pkt_serializer.sv
// Splits a wide trace packet into NUM_BEATS narrow AXI-Stream beats, LS slice first.
// TRACE_PKT_SERIALIZER_SEQ_HEADER_EN prepends a sequence-number header beat per packet.
module trace_pkt_serializer
    import continuous_monitoring_system_pkg::*;
#(
    parameter int unsigned IN_WIDTH  = AXI_DATA_WIDTH,
    parameter int unsigned OUT_WIDTH = 64
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 S_AXIS_tvalid,
    output logic                 S_AXIS_tready,
    input  logic [IN_WIDTH-1:0]  S_AXIS_tdata,
    input  logic                 S_AXIS_tlast,
    output logic                 M_AXIS_tvalid,
    input  logic                 M_AXIS_tready,
    output logic [OUT_WIDTH-1:0] M_AXIS_tdata,
    output logic                 M_AXIS_tlast,
    output logic [31:0]          pkt_count,
    output logic                 busy
);

    localparam int unsigned       NUM_BEATS = IN_WIDTH / OUT_WIDTH;
    localparam int unsigned       BEAT_W    = $clog2(NUM_BEATS);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(NUM_BEATS - 1);

    if ((IN_WIDTH % OUT_WIDTH) != 0 || NUM_BEATS < 2) begin : g_bad_width
        $error("trace_pkt_serializer: IN_WIDTH must be a multiple (>=2x) of OUT_WIDTH");
    end

    ser_state_t          state;
    logic [BEAT_W-1:0]   beat;
    logic [BEAT_W-1:0]   beat_nxt;
    logic [IN_WIDTH-1:0] hold;
    logic                hold_last;
    logic                on_last;
    logic                in_hs;
    logic                out_hs;

    // Ready opens on the final beat so the next packet loads without a bubble.
    assign on_last       = (state == SEND) && (beat == LAST_BEAT);
    assign S_AXIS_tready = rst_n && ((state == IDLE) || (on_last && M_AXIS_tready));
    assign in_hs         = S_AXIS_tvalid && S_AXIS_tready;
    assign out_hs        = M_AXIS_tvalid && M_AXIS_tready;
    assign beat_nxt      = beat + 1'b1;
    assign busy          = (state != IDLE);

`ifdef TRACE_PKT_SERIALIZER_SEQ_HEADER_EN
    if (OUT_WIDTH < 64) begin : g_bad_hdr
        $error("trace_pkt_serializer: header beat needs OUT_WIDTH >= 64");
    end

    // Sequence number is the count before this packet's increment.
    logic [OUT_WIDTH-1:0] hdr_word;
    assign hdr_word = OUT_WIDTH'({pkt_count, 16'(NUM_BEATS), HDR_MAGIC});
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            beat          <= '0;
            hold          <= '0;
            hold_last     <= 1'b0;
            pkt_count     <= '0;
            M_AXIS_tvalid <= 1'b0;
            M_AXIS_tlast  <= 1'b0;
            M_AXIS_tdata  <= '0;
        end else if (in_hs) begin
            hold          <= S_AXIS_tdata;
            hold_last     <= S_AXIS_tlast;
            beat          <= '0;
            pkt_count     <= pkt_count + 32'd1;
            M_AXIS_tvalid <= 1'b1;
            M_AXIS_tlast  <= 1'b0;
`ifdef TRACE_PKT_SERIALIZER_SEQ_HEADER_EN
            state         <= HEADER;
            M_AXIS_tdata  <= hdr_word;
`else
            state         <= SEND;
            M_AXIS_tdata  <= S_AXIS_tdata[OUT_WIDTH-1:0];
`endif
        end else if (out_hs) begin
            case (state)
`ifdef TRACE_PKT_SERIALIZER_SEQ_HEADER_EN
                HEADER: begin
                    state        <= SEND;
                    M_AXIS_tdata <= hold[OUT_WIDTH-1:0];
                    M_AXIS_tlast <= 1'b0;
                end
`endif
                SEND: begin
                    if (on_last) begin
                        state         <= IDLE;
                        M_AXIS_tvalid <= 1'b0;
                        M_AXIS_tlast  <= 1'b0;
                    end else begin
                        beat         <= beat_nxt;
                        M_AXIS_tdata <= hold[beat_nxt*OUT_WIDTH +: OUT_WIDTH];
                        M_AXIS_tlast <= hold_last && (beat_nxt == LAST_BEAT);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_trace_pkt_serializer.sv
// Directed self-checking bench for trace_pkt_serializer (IN_WIDTH=256, OUT_WIDTH=64).
// Runs the header sequence instead when TRACE_PKT_SERIALIZER_SEQ_HEADER_EN is defined.
module tb_trace_pkt_serializer;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         s_valid;
    logic         s_ready;
    logic [255:0] s_data;
    logic         s_last;
    logic         m_valid;
    logic         m_ready;
    logic [63:0]  m_data;
    logic         m_last;
    logic [31:0]  pkt_count;
    logic         busy;

    int unsigned errors = 0;
    int unsigned checks = 0;

    trace_pkt_serializer #(
        .IN_WIDTH (256),
        .OUT_WIDTH(64)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .S_AXIS_tvalid(s_valid),
        .S_AXIS_tready(s_ready),
        .S_AXIS_tdata (s_data),
        .S_AXIS_tlast (s_last),
        .M_AXIS_tvalid(m_valid),
        .M_AXIS_tready(m_ready),
        .M_AXIS_tdata (m_data),
        .M_AXIS_tlast (m_last),
        .pkt_count    (pkt_count),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Packet whose four 64-bit slices are first, first+1, first+2, first+3 (LS first).
    function automatic logic [255:0] mkpkt(input int unsigned first);
        return {64'(first + 3), 64'(first + 2), 64'(first + 1), 64'(first)};
    endfunction

    logic [63:0] exp_dat [8] = '{64'd13, 64'd14, 64'd14, 64'd14, 64'd15, 64'd16, 64'd16, 64'd16};
    logic        rdy_pat [8] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};

    initial begin
        rst_n   = 1'b0;
        s_valid = 1'b0;
        s_data  = '0;
        s_last  = 1'b0;
        m_ready = 1'b1;
        #2;
        check("rst_s_ready", 64'(s_ready), 64'd0);
        check("rst_m_valid", 64'(m_valid), 64'd0);
        check("rst_m_data", m_data, 64'd0);
        check("rst_m_last", 64'(m_last), 64'd0);
        check("rst_pkt_count", 64'(pkt_count), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        tick();
        tick();
        rst_n = 1'b1;
        #1;
        check("post_rst_s_ready", 64'(s_ready), 64'd1);

`ifdef TRACE_PKT_SERIALIZER_SEQ_HEADER_EN
        begin
            int unsigned pkt_i;
            logic        hs;
            logic [63:0] exp;
            s_valid = 1'b1;
            s_data  = mkpkt(1);
            s_last  = 1'b1;
            check("hdr_first_s_ready", 64'(s_ready), 64'd1);
            tick();
            pkt_i  = 1;
            s_data = mkpkt(5);
            for (int unsigned c = 0; c < 15; c++) begin
                if (c % 5 == 0)
                    exp = {32'(c / 5), 16'd4, 16'hC5A1};
                else
                    exp = 64'((c / 5) * 4 + (c % 5));
                check("hdr_valid", 64'(m_valid), 64'd1);
                check("hdr_data", m_data, exp);
                check("hdr_last", 64'(m_last), 64'(c % 5 == 4));
                check("hdr_s_ready", 64'(s_ready), 64'(c % 5 == 4));
                if (c % 5 == 0)
                    check("hdr_low32", 64'(m_data[31:0]), 64'h0004_C5A1);
                hs = s_valid && s_ready;
                tick();
                if (hs) begin
                    pkt_i++;
                    if (pkt_i < 3)
                        s_data = mkpkt(pkt_i * 4 + 1);
                    else
                        s_valid = 1'b0;
                end
            end
            check("hdr_end_valid", 64'(m_valid), 64'd0);
            check("hdr_pkt_count", 64'(pkt_count), 64'd3);
        end
`else
        // Single packet, tlast set, downstream always ready.
        s_valid = 1'b1;
        s_data  = mkpkt(1);
        s_last  = 1'b1;
        check("t1_s_ready", 64'(s_ready), 64'd1);
        tick();
        s_valid = 1'b0;
        check("t1_pkt_count", 64'(pkt_count), 64'd1);
        check("t1_busy", 64'(busy), 64'd1);
        for (int unsigned k = 0; k < 4; k++) begin
            check("t1_valid", 64'(m_valid), 64'd1);
            check("t1_data", m_data, 64'(k + 1));
            check("t1_last", 64'(m_last), 64'(k == 3));
            check("t1_s_ready", 64'(s_ready), 64'(k == 3));
            tick();
        end
        check("t1_end_valid", 64'(m_valid), 64'd0);
        check("t1_end_busy", 64'(busy), 64'd0);

        // Two packets back-to-back: first without tlast, second with.
        s_valid = 1'b1;
        s_data  = mkpkt(5);
        s_last  = 1'b0;
        tick();
        s_data = mkpkt(9);
        s_last = 1'b1;
        for (int unsigned k = 0; k < 8; k++) begin
            check("t2_valid", 64'(m_valid), 64'd1);
            check("t2_data", m_data, 64'(k + 5));
            check("t2_last", 64'(m_last), 64'(k == 7));
            check("t2_s_ready", 64'(s_ready), 64'(k % 4 == 3));
            tick();
            if (k == 3)
                s_valid = 1'b0;
        end
        check("t2_end_valid", 64'(m_valid), 64'd0);
        check("t2_pkt_count", 64'(pkt_count), 64'd3);

        // Downstream stalls: data must hold while ready is low.
        s_valid = 1'b1;
        s_data  = mkpkt(13);
        s_last  = 1'b1;
        tick();
        s_valid = 1'b0;
        for (int unsigned c = 0; c < 8; c++) begin
            m_ready = rdy_pat[c];
            check("t3_valid", 64'(m_valid), 64'd1);
            check("t3_data", m_data, exp_dat[c]);
            check("t3_last", 64'(m_last), 64'(exp_dat[c] == 64'd16));
            tick();
        end
        m_ready = 1'b1;
        check("t3_end_valid", 64'(m_valid), 64'd0);
        check("t3_pkt_count", 64'(pkt_count), 64'd4);

        // Reset in the middle of a packet.
        s_valid = 1'b1;
        s_data  = mkpkt(17);
        tick();
        s_valid = 1'b0;
        check("t4_beat0", m_data, 64'd17);
        tick();
        check("t4_beat1", m_data, 64'd18);
        tick();
        rst_n = 1'b0;
        #1;
        check("t4_rst_valid", 64'(m_valid), 64'd0);
        check("t4_rst_pkt_count", 64'(pkt_count), 64'd0);
        check("t4_rst_s_ready", 64'(s_ready), 64'd0);
        check("t4_rst_busy", 64'(busy), 64'd0);
        #1;
        rst_n = 1'b1;
        for (int unsigned c = 0; c < 2; c++) begin
            tick();
            check("t4_no_partial", 64'(m_valid), 64'd0);
        end
        s_valid = 1'b1;
        s_data  = mkpkt(21);
        s_last  = 1'b0;
        tick();
        s_valid = 1'b0;
        check("t4_new_pkt_count", 64'(pkt_count), 64'd1);
        for (int unsigned k = 0; k < 4; k++) begin
            check("t4_new_valid", 64'(m_valid), 64'd1);
            check("t4_new_data", m_data, 64'(k + 21));
            check("t4_new_last", 64'(m_last), 64'd0);
            tick();
        end
        check("t4_end_valid", 64'(m_valid), 64'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
